// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and shared enums for the dispatch sequencer
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    CLS_INT,
    CLS_LS,
    CLS_MULT,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } inst_class_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BR_WAIT,
    ST_FLUSH
  } disp_state_t;

endpackage

// File: rtl/dispatch_ctrl_if.sv
// rtl/dispatch_ctrl_if.sv - IFQ / issue-queue / branch bundle; stats ports exist only with DISPATCH_STATS_EN
interface dispatch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0] Ifq_Inst;
  logic [31:0] Ifq_Pc;
  logic        Ifq_Empty;
  logic        Ifq_RdEn;
  logic        Ifq_Flush;
  logic        IssueQ_Full_Int;
  logic        IssueQ_Full_LS;
  logic        IssueQ_Full_Mult;
  logic [31:0] Dispatch_Inst;
  logic        Dispatch_en_Int;
  logic        Dispatch_en_LS;
  logic        Dispatch_en_Mult;
  logic        Branch_Valid;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Addr;
  logic        Illegal_Inst;
  logic        Stall;
`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] Stat_Int;
  logic [CNT_W-1:0] Stat_LS;
  logic [CNT_W-1:0] Stat_Mult;
  logic [CNT_W-1:0] Stat_Stall;

  modport master (
    input  Ifq_Inst, Ifq_Pc, Ifq_Empty, IssueQ_Full_Int, IssueQ_Full_LS, IssueQ_Full_Mult,
    input  Branch_Valid, Branch_Taken, Branch_Target,
    output Ifq_RdEn, Ifq_Flush, Dispatch_Inst, Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult,
    output Redirect_Valid, Redirect_Addr, Illegal_Inst, Stall,
    output Stat_Int, Stat_LS, Stat_Mult, Stat_Stall
  );

  modport slave (
    output Ifq_Inst, Ifq_Pc, Ifq_Empty, IssueQ_Full_Int, IssueQ_Full_LS, IssueQ_Full_Mult,
    output Branch_Valid, Branch_Taken, Branch_Target,
    input  Ifq_RdEn, Ifq_Flush, Dispatch_Inst, Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult,
    input  Redirect_Valid, Redirect_Addr, Illegal_Inst, Stall,
    input  Stat_Int, Stat_LS, Stat_Mult, Stat_Stall
  );
`else
  modport master (
    input  Ifq_Inst, Ifq_Pc, Ifq_Empty, IssueQ_Full_Int, IssueQ_Full_LS, IssueQ_Full_Mult,
    input  Branch_Valid, Branch_Taken, Branch_Target,
    output Ifq_RdEn, Ifq_Flush, Dispatch_Inst, Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult,
    output Redirect_Valid, Redirect_Addr, Illegal_Inst, Stall
  );

  modport slave (
    output Ifq_Inst, Ifq_Pc, Ifq_Empty, IssueQ_Full_Int, IssueQ_Full_LS, IssueQ_Full_Mult,
    output Branch_Valid, Branch_Taken, Branch_Target,
    input  Ifq_RdEn, Ifq_Flush, Dispatch_Inst, Dispatch_en_Int, Dispatch_en_LS, Dispatch_en_Mult,
    input  Redirect_Valid, Redirect_Addr, Illegal_Inst, Stall
  );
`endif
endinterface

// File: rtl/dispatch_class_decode.sv
// rtl/dispatch_class_decode.sv - combinational instruction class decode
module dispatch_class_decode
  import mips_pkg::*;
(
  input  logic [31:0] inst_i,
  output inst_class_t cls_o
);

  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_i[25:6];

  always_comb begin
    cls_o = CLS_ILLEGAL;
    case (inst_i[31:26])
      OP_RTYPE: begin
        case (inst_i[5:0])
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL: cls_o = CLS_INT;
          FN_MULT:                         cls_o = CLS_MULT;
          default:                         cls_o = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cls_o = CLS_INT;
      OP_LW, OP_SW:                                cls_o = CLS_LS;
      OP_BEQ, OP_BNE:                              cls_o = CLS_BRANCH;
      OP_J:                                        cls_o = CLS_JUMP;
      default:                                     cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - IFQ-to-issue-queue dispatch FSM with branch hold and fetch redirect/flush
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module dispatch_ctrl
  import mips_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic             Clk,
  input logic             Rst,
  dispatch_ctrl_if.master bus
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  inst_class_t cls;
  disp_state_t state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        q_full, pop, stall;

  logic [31:0] inst_q, inst_d;
  logic        en_int_q, en_int_d, en_ls_q, en_ls_d, en_mult_q, en_mult_d;
  logic        redir_valid_q, redir_valid_d, illegal_q, illegal_d;
  logic [31:0] redir_addr_q, redir_addr_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.Ifq_Pc[27:0];

  dispatch_class_decode u_decode (
    .inst_i (bus.Ifq_Inst),
    .cls_o  (cls)
  );

  // Branches occupy an Int slot; jumps and illegal words never enter a queue.
  always_comb begin
    q_full = 1'b0;
    case (cls)
      CLS_INT, CLS_BRANCH: q_full = bus.IssueQ_Full_Int;
      CLS_LS:              q_full = bus.IssueQ_Full_LS;
      CLS_MULT:            q_full = bus.IssueQ_Full_Mult;
      default:             q_full = 1'b0;
    endcase
  end

  assign pop   = (state_q == ST_RUN) && !bus.Ifq_Empty && !q_full;
  assign stall = !bus.Ifq_Empty && !pop;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    inst_d        = inst_q;
    en_int_d      = 1'b0;
    en_ls_d       = 1'b0;
    en_mult_d     = 1'b0;
    redir_valid_d = 1'b0;
    redir_addr_d  = redir_addr_q;
    illegal_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pop) begin
          inst_d = bus.Ifq_Inst;
          case (cls)
            CLS_INT:  en_int_d  = 1'b1;
            CLS_LS:   en_ls_d   = 1'b1;
            CLS_MULT: en_mult_d = 1'b1;
            CLS_BRANCH: begin
              en_int_d = 1'b1;
              state_d  = ST_BR_WAIT;
            end
            CLS_JUMP: begin
              redir_valid_d = 1'b1;
              redir_addr_d  = {bus.Ifq_Pc[31:28], bus.Ifq_Inst[25:0], 2'b00};
              state_d       = ST_FLUSH;
              flush_cnt_d   = FLUSH_LOAD;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_BR_WAIT: begin
        if (bus.Branch_Valid) begin
          if (bus.Branch_Taken) begin
            redir_valid_d = 1'b1;
            redir_addr_d  = bus.Branch_Target;
            state_d       = ST_FLUSH;
            flush_cnt_d   = FLUSH_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = ST_RUN;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 4'd0;
      inst_q        <= 32'd0;
      en_int_q      <= 1'b0;
      en_ls_q       <= 1'b0;
      en_mult_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= 32'd0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      inst_q        <= inst_d;
      en_int_q      <= en_int_d;
      en_ls_q       <= en_ls_d;
      en_mult_q     <= en_mult_d;
      redir_valid_q <= redir_valid_d;
      redir_addr_q  <= redir_addr_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.Ifq_RdEn         = pop;
  assign bus.Ifq_Flush        = (state_q == ST_FLUSH);
  assign bus.Stall            = stall;
  assign bus.Dispatch_Inst    = inst_q;
  assign bus.Dispatch_en_Int  = en_int_q;
  assign bus.Dispatch_en_LS   = en_ls_q;
  assign bus.Dispatch_en_Mult = en_mult_q;
  assign bus.Redirect_Valid   = redir_valid_q;
  assign bus.Redirect_Addr    = redir_addr_q;
  assign bus.Illegal_Inst     = illegal_q;

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] stat_int_q, stat_int_d, stat_ls_q, stat_ls_d;
  logic [CNT_W-1:0] stat_mult_q, stat_mult_d, stat_stall_q, stat_stall_d;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_comb begin
    stat_int_d   = stat_int_q;
    stat_ls_d    = stat_ls_q;
    stat_mult_d  = stat_mult_q;
    stat_stall_d = stat_stall_q;
    if (en_int_q  && stat_int_q   != '1) stat_int_d   = stat_int_q + 1'b1;
    if (en_ls_q   && stat_ls_q    != '1) stat_ls_d    = stat_ls_q + 1'b1;
    if (en_mult_q && stat_mult_q  != '1) stat_mult_d  = stat_mult_q + 1'b1;
    if (stall     && stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stat_int_q   <= '0;
      stat_ls_q    <= '0;
      stat_mult_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_int_q   <= stat_int_d;
      stat_ls_q    <= stat_ls_d;
      stat_mult_q  <= stat_mult_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign bus.Stat_Int   = stat_int_q;
  assign bus.Stat_LS    = stat_ls_q;
  assign bus.Stat_Mult  = stat_mult_q;
  assign bus.Stat_Stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - scoreboard bench for dispatch_ctrl; stats checks built with DISPATCH_STATS_EN
module tb_dispatch_ctrl;

  localparam int FLUSH_CYCLES = 2;
`ifdef DISPATCH_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dispatch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  flags;   // {en_int, en_ls, en_mult, illegal, redirect}
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0 = dispatching, 1 = waiting on branch, 2 = flushing.
  int m_mode = 0;
  int m_flush_left = 0;

  logic [5:0] fn_tab[10] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
  logic [5:0] imm_tab[5] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // 0 INT, 1 LS, 2 MULT, 3 BRANCH, 4 JUMP, 5 ILLEGAL
  function automatic int ref_class(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      for (int i = 0; i < 10; i++) if (fn == fn_tab[i]) return 0;
      if (fn == 6'h18) return 2;
      return 5;
    end
    for (int i = 0; i < 5; i++) if (op == imm_tab[i]) return 0;
    if (op == 6'h23 || op == 6'h2B) return 1;
    if (op == 6'h04 || op == 6'h05) return 3;
    if (op == 6'h02) return 4;
    return 5;
  endfunction

  function automatic exp_t mk(input logic [4:0] f, input logic [31:0] i, input logic [31:0] a);
    exp_t e;
    e.flags = f;
    e.inst  = i;
    e.addr  = a;
    return e;
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit empty, input logic [31:0] inst, input logic [31:0] pc,
                      input bit fi, input bit fls, input bit fm,
                      input bit bv, input bit bt, input logic [31:0] tgt, output bit popped);
    bit rd, fl, full;
    int c;
    bus.Ifq_Empty        = empty;
    bus.Ifq_Inst         = inst;
    bus.Ifq_Pc           = pc;
    bus.IssueQ_Full_Int  = fi;
    bus.IssueQ_Full_LS   = fls;
    bus.IssueQ_Full_Mult = fm;
    bus.Branch_Valid     = bv;
    bus.Branch_Taken     = bt;
    bus.Branch_Target    = tgt;
    #1;
    rd = 0;
    fl = 0;
    c  = ref_class(inst);
    full = (c == 0 || c == 3) ? fi : (c == 1) ? fls : (c == 2) ? fm : 1'b0;
    if (m_mode == 0) begin
      rd = !empty && !full;
      if (rd) begin
        case (c)
          0: expq.push_back(mk(5'b10000, inst, 0));
          1: expq.push_back(mk(5'b01000, inst, 0));
          2: expq.push_back(mk(5'b00100, inst, 0));
          3: begin expq.push_back(mk(5'b10000, inst, 0)); m_mode = 1; end
          4: begin
            expq.push_back(mk(5'b00001, inst, {pc[31:28], inst[25:0], 2'b00}));
            m_mode = 2;
            m_flush_left = FLUSH_CYCLES;
          end
          default: expq.push_back(mk(5'b00010, inst, 0));
        endcase
      end
    end else if (m_mode == 1) begin
      if (bv) begin
        if (bt) begin
          expq.push_back(mk(5'b00001, 0, tgt));
          m_mode = 2;
          m_flush_left = FLUSH_CYCLES;
        end else begin
          m_mode = 0;
        end
      end
    end else begin
      fl = 1;
      m_flush_left--;
      if (m_flush_left == 0) m_mode = 0;
    end
    check("rd_en", {31'd0, bus.Ifq_RdEn}, {31'd0, rd});
    check("stall", {31'd0, bus.Stall}, {31'd0, (!empty && !rd)});
    check("flush", {31'd0, bus.Ifq_Flush}, {31'd0, fl});
    popped = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.Ifq_Empty        = 1'b1;
    bus.Ifq_Inst         = 32'd0;
    bus.Ifq_Pc           = 32'd0;
    bus.IssueQ_Full_Int  = 1'b0;
    bus.IssueQ_Full_LS   = 1'b0;
    bus.IssueQ_Full_Mult = 1'b0;
    bus.Branch_Valid     = 1'b0;
    bus.Branch_Taken     = 1'b0;
    bus.Branch_Target    = 32'd0;
    @(posedge clk);
    #1;
    check("rst_en_int", {31'd0, bus.Dispatch_en_Int}, 0);
    check("rst_en_ls", {31'd0, bus.Dispatch_en_LS}, 0);
    check("rst_en_mult", {31'd0, bus.Dispatch_en_Mult}, 0);
    check("rst_redirect", {31'd0, bus.Redirect_Valid}, 0);
    check("rst_illegal", {31'd0, bus.Illegal_Inst}, 0);
    check("rst_inst", bus.Dispatch_Inst, 0);
    check("rst_addr", bus.Redirect_Addr, 0);
    check("rst_flush", {31'd0, bus.Ifq_Flush}, 0);
    check("rst_stall", {31'd0, bus.Stall}, 0);
`ifdef DISPATCH_STATS_EN
    check("rst_stat_mult", 32'(bus.Stat_Mult), 0);
`endif
    m_mode = 0;
    m_flush_left = 0;
    expq.delete();
    rst = 1'b0;
  endtask

  // Monitor: whenever the DUT presents a dispatch, redirect or illegal pulse, match it against the scoreboard.
  always @(negedge clk) begin
    logic [4:0] f;
    exp_t e;
    f = {bus.Dispatch_en_Int, bus.Dispatch_en_LS, bus.Dispatch_en_Mult, bus.Illegal_Inst, bus.Redirect_Valid};
    if (f != 5'b0) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: actual flags=%b required none", f);
      end else begin
        e = expq.pop_front();
        check("mon_flags", {27'd0, f}, {27'd0, e.flags});
        if (e.flags[4:2] != 3'b0) check("mon_inst", bus.Dispatch_Inst, e.inst);
        if (e.flags[0]) check("mon_addr", bus.Redirect_Addr, e.addr);
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin r[31:26] = 6'h00; r[5:0] = fn_tab[$urandom_range(0, 9)]; end
      2:    begin r[31:26] = 6'h00; r[5:0] = 6'h18; end
      3:    r[31:26] = imm_tab[$urandom_range(0, 4)];
      4, 5: r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B;
      6:    r[31:26] = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
      7:    r[31:26] = 6'h02;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    bit p;
    logic [31:0] head, pc;
    do_reset();

    // ADD straight through to Int
    step(0, 32'h012A4020, 32'h00400000, 0, 0, 0, 0, 0, 0, p);
    check("add_en_int", {31'd0, bus.Dispatch_en_Int}, 1);
    check("add_inst", bus.Dispatch_Inst, 32'h012A4020);
    idle(1);

    // LW held three cycles by a full LS queue
    for (int i = 0; i < 3; i++) step(0, 32'h8D090004, 32'h00400004, 0, 1, 0, 0, 0, 0, p);
    step(0, 32'h8D090004, 32'h00400004, 0, 0, 0, 0, 0, 0, p);
    check("lw_en_ls", {31'd0, bus.Dispatch_en_LS}, 1);
    idle(1);

    // BEQ, ADD held until not-taken resolution
    step(0, 32'h11090003, 32'h00400008, 0, 0, 0, 0, 0, 0, p);
    for (int i = 0; i < 3; i++) step(0, 32'h012A4020, 32'h0040000C, 0, 0, 0, 0, 0, 0, p);
    step(0, 32'h012A4020, 32'h0040000C, 0, 0, 0, 1, 0, 0, p);
    step(0, 32'h012A4020, 32'h0040000C, 0, 0, 0, 0, 0, 0, p);
    check("beq_add_en", {31'd0, bus.Dispatch_en_Int}, 1);
    idle(1);

    // BNE taken: redirect, flush, then resume
    step(0, 32'h15090003, 32'h00400010, 0, 0, 0, 0, 0, 0, p);
    step(0, 32'h012A4020, 32'h00400014, 0, 0, 0, 1, 1, 32'h00400100, p);
    check("bne_redirect", {31'd0, bus.Redirect_Valid}, 1);
    check("bne_addr", bus.Redirect_Addr, 32'h00400100);
    for (int i = 0; i < FLUSH_CYCLES + 1; i++) step(0, 32'h012A4020, 32'h00400100, 0, 0, 0, 0, 0, 0, p);
    idle(1);

    // J then an illegal opcode
    step(0, 32'h08100040, 32'h00400008, 0, 0, 0, 0, 0, 0, p);
    check("j_addr", bus.Redirect_Addr, 32'h00400100);
    check("j_no_en", {29'd0, bus.Dispatch_en_Int, bus.Dispatch_en_LS, bus.Dispatch_en_Mult}, 0);
    for (int i = 0; i < FLUSH_CYCLES + 1; i++) step(0, 32'hFC000000, 32'h00400100, 0, 0, 0, 0, 0, 0, p);
    check("ill_pulse", {31'd0, bus.Illegal_Inst}, 1);
    idle(1);

    // Reset in the middle of a branch wait
    step(0, 32'h11090003, 32'h00400020, 0, 0, 0, 0, 0, 0, p);
    step(0, 32'h012A4020, 32'h00400024, 0, 0, 0, 0, 0, 0, p);
    do_reset();
    step(0, 32'h012A4020, 32'h00400024, 0, 0, 0, 0, 0, 0, p);
    idle(1);

    // Randomized traffic; the head stays until popped
    head = rand_inst();
    pc   = {$urandom} & 32'hFFFFFFFC;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, head, pc,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom, p);
      if (p) begin
        head = rand_inst();
        pc   = pc + 32'd4;
      end
    end
    idle(FLUSH_CYCLES + 2);

`ifdef DISPATCH_STATS_EN
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 32'h01090018, 32'h00400000, 0, 0, 0, 0, 0, 0, p);
    idle(2);
    check("stat_mult_sat", 32'(bus.Stat_Mult), 15);
    check("stat_int_zero", 32'(bus.Stat_Int), 0);
`endif

    check("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
